// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: opcodes, FSM states,
// default operand width and counter width.
package muldiv_pkg;
  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = $clog2(XLEN_DEF);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  // Even opcodes are the signed variants, the upper bit selects divide.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/muldiv_unit_cond_neg.sv
// Conditional two's-complement negation, used for operand magnitudes and
// for restoring the sign of product, quotient and remainder.
module cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] in_i,
  input  logic         neg_i,
  output logic [W-1:0] out_o
);
  assign out_o = neg_i ? (-in_i) : in_i;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add or restoring-divide step per cycle; busy stalls the pipeline.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            mthi,
  input  logic            mtlo,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [1:0]      dbg_state
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              is_div_q, is_div_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              done_q, done_d;

  logic              sgn_a, sgn_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_rem, div_trial;
  logic [2*XLEN-1:0] step, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;
  logic              div_by_zero;

  assign sgn_a = op_is_signed(op) & src_a[XLEN-1];
  assign sgn_b = op_is_signed(op) & src_b[XLEN-1];

  cond_neg #(.W(XLEN)) u_abs_a (.in_i(src_a), .neg_i(sgn_a), .out_o(mag_a));
  cond_neg #(.W(XLEN)) u_abs_b (.in_i(src_b), .neg_i(sgn_b), .out_o(mag_b));

  // Multiply keeps the multiplier in acc low half; divide keeps the dividend there
  // and builds the partial remainder in the high half (one extra bit for the shift).
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
  assign div_rem   = acc_q[2*XLEN-1:XLEN-1];
  assign div_trial = div_rem - {1'b0, opnd_q};

  always_comb begin
    step = acc_q;
    if (is_div_q) begin
      if (!div_trial[XLEN]) step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                  step = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      if (acc_q[0]) step = {mul_sum, acc_q[XLEN-1:1]};
      else          step = {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  cond_neg #(.W(2*XLEN)) u_prod_fix (.in_i(acc_q), .neg_i(neg_a_q ^ neg_b_q), .out_o(prod_fix));
  cond_neg #(.W(XLEN)) u_quot_fix (.in_i(acc_q[XLEN-1:0]), .neg_i(neg_a_q ^ neg_b_q),
                                   .out_o(quot_fix));
  cond_neg #(.W(XLEN)) u_rem_fix (.in_i(acc_q[2*XLEN-1:XLEN]), .neg_i(neg_a_q), .out_o(rem_fix));

  // With a zero divisor the remainder path already yields the raw dividend.
  assign div_by_zero = (opnd_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CALC;
          cnt_d    = '0;
          acc_d    = {{XLEN{1'b0}}, op_is_div(op) ? mag_a : mag_b};
          opnd_d   = op_is_div(op) ? mag_b : mag_a;
          is_div_d = op_is_div(op);
          neg_a_d  = sgn_a;
          neg_b_d  = sgn_b;
        end else begin
          if (mthi) hi_d = src_a;
          if (mtlo) lo_d = src_a;
        end
      end
      ST_CALC: begin
        acc_d = step;
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d = div_by_zero ? {XLEN{1'b1}} : quot_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;
endmodule
